// File: rtl/ascon_serial_host.sv
// ascon_serial_host: request/response wrapper around a bit-serial Ascon-128 core.
// Serialises key/nonce/AD/text/tag MSB first, starts the core, collects results LSB first.
//
// state | meaning
// IDLE  | waiting for a request (req_ready high)
// CRST  | one-cycle reset pulse to the core
// SHIFT | 128 cycles of serial operands to the core
// GAP   | one idle cycle before the start pulse
// START | one-cycle encrypt or decrypt start pulse
// WAIT  | waiting for the selected core ready, bounded by TIMEOUT
// CAPT  | sampling 128 result bits
// DONE  | result held until res_ready
module ascon_serial_host #(
  parameter int KEY_L   = 128,
  parameter int A_L     = 40,
  parameter int TEXT_L  = 40,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_mode,
  input  logic [KEY_L-1:0]  req_key,
  input  logic [127:0]      req_nonce,
  input  logic [A_L-1:0]    req_ad,
  input  logic [TEXT_L-1:0] req_text,
  input  logic [127:0]      req_tag,
  output logic              core_rst_o,
  output logic              key_o,
  output logic              nonce_o,
  output logic              assoc_o,
  output logic              pt_o,
  output logic              tag_o,
  output logic              en_start_o,
  output logic              dec_start_o,
  input  logic              ciphertext_i,
  input  logic              plaintext_i,
  input  logic              tag_i,
  input  logic              dectag_i,
  input  logic              en_ready_i,
  input  logic              de_ready_i,
  input  logic              msg_auth_i,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [TEXT_L-1:0] res_text,
  output logic [127:0]      res_tag,
  output logic              res_auth,
  output logic              res_err
);

  // wide enough for both the 0..127 bit index and the WAIT timeout count
  localparam int CW = ($clog2(TIMEOUT) > 7) ? $clog2(TIMEOUT) : 7;

  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_SHIFT, S_GAP, S_START, S_WAIT, S_CAPT, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic                r_mode;
  logic [KEY_L-1:0]    r_key;
  logic [127:0]        r_nonce;
  logic [A_L-1:0]      r_ad;
  logic [TEXT_L-1:0]   r_text;
  logic [127:0]        r_tag;
  logic [TEXT_L-1:0]   r_res_text;
  logic [127:0]        r_res_tag;
  logic                r_res_auth;
  logic                r_res_err;

  logic w_shift;
  logic w_rdy;
  logic w_cnt_last;
  logic w_cnt_to;
  logic w_txt_bit;
  logic w_tag_bit;

  assign w_shift    = (r_state == S_SHIFT);
  assign w_rdy      = r_mode ? de_ready_i : en_ready_i;
  assign w_cnt_last = (r_cnt == CW'(127));
  assign w_cnt_to   = (r_cnt == CW'(TIMEOUT - 1));
  assign w_txt_bit  = r_mode ? plaintext_i : ciphertext_i;
  assign w_tag_bit  = r_mode ? dectag_i : tag_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_nxt = S_CRST;
      S_CRST:  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_cnt_last) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_rdy)         w_state_nxt = S_CAPT;
        else if (w_cnt_to) w_state_nxt = S_DONE;
      end
      S_CAPT:  if (!w_rdy || w_cnt_last) w_state_nxt = S_DONE;
      S_DONE:  if (res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mode     <= 1'b0;
      r_key      <= '0;
      r_nonce    <= '0;
      r_ad       <= '0;
      r_text     <= '0;
      r_tag      <= '0;
      r_res_text <= '0;
      r_res_tag  <= '0;
      r_res_auth <= 1'b0;
      r_res_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_mode     <= req_mode;
            r_key      <= req_key;
            r_nonce    <= req_nonce;
            r_ad       <= req_ad;
            r_text     <= req_text;
            r_tag      <= req_tag;
            r_res_text <= '0;
            r_res_tag  <= '0;
            r_res_auth <= 1'b0;
            r_res_err  <= 1'b0;
            r_cnt      <= '0;
          end
        end
        S_SHIFT: begin
          // zero fill makes AD and text read as 0 past their own length
          r_key   <= r_key << 1;
          r_nonce <= r_nonce << 1;
          r_ad    <= r_ad << 1;
          r_text  <= r_text << 1;
          r_tag   <= r_tag << 1;
          r_cnt   <= w_cnt_last ? '0 : r_cnt + CW'(1);
        end
        S_WAIT: begin
          if (w_rdy) begin
            r_res_auth <= r_mode & msg_auth_i;
            r_cnt      <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (w_cnt_to) r_res_err <= 1'b1;
          end
        end
        S_CAPT: begin
          if (w_rdy) begin
            r_res_text <= r_res_text | (TEXT_L'(w_txt_bit) << r_cnt);
            r_res_tag  <= r_res_tag | (128'(w_tag_bit) << r_cnt);
            r_cnt      <= r_cnt + CW'(1);
          end else begin
            r_res_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign core_rst_o  = rst | (r_state == S_CRST);
  assign key_o       = w_shift & r_key[KEY_L-1];
  assign nonce_o     = w_shift & r_nonce[127];
  assign assoc_o     = w_shift & r_ad[A_L-1];
  assign pt_o        = w_shift & r_text[TEXT_L-1];
  assign tag_o       = w_shift & r_tag[127];
  assign en_start_o  = (r_state == S_START) & ~r_mode;
  assign dec_start_o = (r_state == S_START) & r_mode;
  assign res_valid   = (r_state == S_DONE);
  assign res_text    = r_res_text;
  assign res_tag     = r_res_tag;
  assign res_auth    = r_res_auth;
  assign res_err     = r_res_err;

endmodule

// File: tb/tb_ascon_serial_host.sv
// Bench for ascon_serial_host: behavioural Ascon-128 serial core plus a result scoreboard.
`timescale 1ns/1ps
module tb_ascon_serial_host;
  localparam int TO  = 16;
  localparam int LAT = 4;
  localparam logic [127:0] K  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] NC = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [39:0]  AD = 40'h0102030405;
  localparam logic [39:0]  PT = 40'h4142434445;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid, req_ready, req_mode;
  logic [127:0] req_key, req_nonce, req_tag;
  logic [39:0]  req_ad, req_text;
  logic core_rst_o, key_o, nonce_o, assoc_o, pt_o, tag_o, en_start_o, dec_start_o;
  logic ciphertext_i, plaintext_i, tag_i, dectag_i, en_ready_i, de_ready_i, msg_auth_i;
  logic res_valid, res_ready, res_auth, res_err;
  logic [39:0]  res_text;
  logic [127:0] res_tag;

  always #5 clk = ~clk;

  ascon_serial_host #(.KEY_L(128), .A_L(40), .TEXT_L(40), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_key(req_key), .req_nonce(req_nonce), .req_ad(req_ad), .req_text(req_text),
    .req_tag(req_tag), .core_rst_o(core_rst_o), .key_o(key_o), .nonce_o(nonce_o),
    .assoc_o(assoc_o), .pt_o(pt_o), .tag_o(tag_o), .en_start_o(en_start_o),
    .dec_start_o(dec_start_o), .ciphertext_i(ciphertext_i), .plaintext_i(plaintext_i),
    .tag_i(tag_i), .dectag_i(dectag_i), .en_ready_i(en_ready_i), .de_ready_i(de_ready_i),
    .msg_auth_i(msg_auth_i), .res_valid(res_valid), .res_ready(res_ready),
    .res_text(res_text), .res_tag(res_tag), .res_auth(res_auth), .res_err(res_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- Ascon-128 reference ----------------
  typedef logic [4:0][63:0] st_t;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic st_t perm(input st_t s, input int nr);
    st_t x;
    logic [63:0] t0, t1, t2, t3, t4;
    x = s;
    for (int r = 12 - nr; r < 12; r++) begin
      x[2] ^= 64'(((15 - r) << 4) | r);
      x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
      t0 = ~x[0] & x[1]; t1 = ~x[1] & x[2]; t2 = ~x[2] & x[3];
      t3 = ~x[3] & x[4]; t4 = ~x[4] & x[0];
      x[0] ^= t1; x[1] ^= t2; x[2] ^= t3; x[3] ^= t4; x[4] ^= t0;
      x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
      x[0] ^= ror(x[0], 19) ^ ror(x[0], 28);
      x[1] ^= ror(x[1], 61) ^ ror(x[1], 39);
      x[2] ^= ror(x[2], 1)  ^ ror(x[2], 6);
      x[3] ^= ror(x[3], 10) ^ ror(x[3], 17);
      x[4] ^= ror(x[4], 7)  ^ ror(x[4], 41);
    end
    return x;
  endfunction

  task automatic ascon(input logic dec, input logic [127:0] k, input logic [127:0] n,
                       input logic [39:0] ad, input logic [39:0] din,
                       output logic [39:0] dout, output logic [127:0] tag);
    st_t s;
    s[0] = 64'h80400c0600000000; s[1] = k[127:64]; s[2] = k[63:0];
    s[3] = n[127:64]; s[4] = n[63:0];
    s = perm(s, 12);
    s[3] ^= k[127:64]; s[4] ^= k[63:0];
    s[0] ^= {ad, 24'h800000};
    s = perm(s, 6);
    s[4] ^= 64'd1;
    if (dec) begin
      dout = s[0][63:24] ^ din;
      s[0] = {din, s[0][23:0] ^ 24'h800000};
    end else begin
      s[0] ^= {din, 24'h800000};
      dout = s[0][63:24];
    end
    s[1] ^= k[127:64]; s[2] ^= k[63:0];
    s = perm(s, 12);
    tag = {s[3] ^ k[127:64], s[4] ^ k[63:0]};
  endtask

  // ---------------- serial core model ----------------
  int c_mute = 0;
  int c_drop = -1;

  initial begin
    logic [127:0] c_key, c_non, c_ad, c_pt, c_tag, c_sh_out, c_sh_tag, c_tcalc;
    logic [39:0]  c_out;
    int c_cnt, c_t, c_k;
    logic c_busy, c_dec, c_auth;
    {en_ready_i, de_ready_i, msg_auth_i, ciphertext_i, plaintext_i, tag_i, dectag_i} = '0;
    c_cnt = 0; c_t = 0; c_busy = 1'b0; c_dec = 1'b0; c_auth = 1'b0;
    c_key = '0; c_non = '0; c_ad = '0; c_pt = '0; c_tag = '0; c_sh_out = '0; c_sh_tag = '0;
    forever begin
      @(negedge clk);
      if (core_rst_o) begin
        c_cnt = 0; c_busy = 1'b0;
        {en_ready_i, de_ready_i, msg_auth_i, ciphertext_i, plaintext_i, tag_i, dectag_i} = '0;
      end else begin
        if (c_cnt < 128) begin
          c_key = {c_key[126:0], key_o}; c_non = {c_non[126:0], nonce_o};
          c_ad  = {c_ad[126:0], assoc_o}; c_pt  = {c_pt[126:0], pt_o};
          c_tag = {c_tag[126:0], tag_o};
          c_cnt++;
        end
        if (en_start_o || dec_start_o) begin
          c_dec = dec_start_o;
          ascon(c_dec, c_key, c_non, c_ad[127:88], c_pt[127:88], c_out, c_tcalc);
          c_auth = c_dec && (c_tcalc == c_tag);
          if (c_dec && !c_auth) c_out = '1;
          c_sh_out = {88'd0, c_out};
          c_sh_tag = c_tcalc;
          c_busy = 1'b1; c_t = 0;
        end else if (c_busy) begin
          c_t++;
          if (c_t == LAT) begin
            if (c_mute == 0) begin
              if (c_dec) de_ready_i = 1'b1; else en_ready_i = 1'b1;
            end
            msg_auth_i = c_auth;
          end else if (c_t > LAT && c_t <= LAT + 128) begin
            c_k = c_t - LAT - 1;
            if (c_k == c_drop) begin en_ready_i = 1'b0; de_ready_i = 1'b0; end
            if (c_dec) begin plaintext_i = c_sh_out[0]; dectag_i = c_sh_tag[0]; end
            else begin ciphertext_i = c_sh_out[0]; tag_i = c_sh_tag[0]; end
            c_sh_out = c_sh_out >> 1; c_sh_tag = c_sh_tag >> 1;
          end else if (c_t > LAT + 128) begin
            {en_ready_i, de_ready_i, msg_auth_i, ciphertext_i, plaintext_i, tag_i, dectag_i} = '0;
            c_busy = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [39:0]  text;
    logic [127:0] tag;
    logic [39:0]  tmask;
    logic [127:0] gmask;
    logic         auth;
    logic         err;
  } exp_t;
  exp_t sb[$];

  logic [39:0]  g_ct;
  logic [127:0] g_tag;

  task automatic push_exp(input logic dec, input logic [39:0] din, input logic [127:0] tg_in);
    exp_t e;
    logic [39:0]  o;
    logic [127:0] t;
    ascon(dec, K, NC, AD, din, o, t);
    e.auth  = dec && (t == tg_in);
    e.text  = (dec && !e.auth) ? '1 : o;
    e.tag   = t;
    e.tmask = '1; e.gmask = '1; e.err = 1'b0;
    if (c_mute != 0) begin
      e.tmask = '0; e.gmask = '0; e.err = 1'b1; e.auth = 1'b0;
    end else if (c_drop >= 0) begin
      e.err   = 1'b1;
      e.gmask = (128'd1 << c_drop) - 128'd1;
      e.tmask = (c_drop >= 40) ? '1 : ((40'd1 << c_drop) - 40'd1);
    end
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic mode, input logic [39:0] tx, input logic [127:0] tg);
    req_valid = 1'b1; req_mode = mode; req_key = K; req_nonce = NC;
    req_ad = AD; req_text = tx; req_tag = tg;
  endtask

  task automatic scramble_req();
    req_valid = 1'b0; req_mode = ~req_mode;
    req_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
    req_nonce = {$urandom(), $urandom(), $urandom(), $urandom()};
    req_tag   = {$urandom(), $urandom(), $urandom(), $urandom()};
    req_ad    = {8'($urandom()), $urandom()};
    req_text  = {8'($urandom()), $urandom()};
  endtask

  // returns at the negedge right after the acceptance edge
  task automatic start_req(input logic mode, input logic [39:0] tx, input logic [127:0] tg);
    int i;
    @(negedge clk);
    drive_req(mode, tx, tg);
    for (i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++; $display("FAIL accept_wait: req_ready=%b required 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    scramble_req();
    n_checks++;
    if ({res_err, res_valid} !== 2'b00) begin
      n_errors++; $display("FAIL accept_clear: res_err,res_valid=%b required 00", {res_err, res_valid});
    end
  endtask

  task automatic wait_result(input string name);
    exp_t e;
    int i;
    for (i = 0; i < 600 && !res_valid; i++) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_errors++; $display("FAIL %s_timeout: res_valid=%b required 1", name, res_valid);
    end
    if (sb.size() == 0) begin
      $display("FAIL %s_sb_empty: queue size 0 required >0", name);
      $fatal(1, "scoreboard empty");
    end
    e = sb.pop_front();
    n_checks++;
    if ((res_text & e.tmask) !== (e.text & e.tmask)) begin
      n_errors++; $display("FAIL %s_text: got %h required %h", name, res_text & e.tmask, e.text & e.tmask);
    end
    n_checks++;
    if ((res_tag & e.gmask) !== (e.tag & e.gmask)) begin
      n_errors++; $display("FAIL %s_tag: got %h required %h", name, res_tag & e.gmask, e.tag & e.gmask);
    end
    n_checks++;
    if (res_auth !== e.auth) begin
      n_errors++; $display("FAIL %s_auth: got %b required %b", name, res_auth, e.auth);
    end
    n_checks++;
    if (res_err !== e.err) begin
      n_errors++; $display("FAIL %s_err: got %b required %b", name, res_err, e.err);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_ready, core_rst_o, res_valid} !== 3'b110) begin
      n_errors++; $display("FAIL reset_ctrl: ready,core_rst,valid=%b required 110", {req_ready, core_rst_o, res_valid});
    end
    n_checks++;
    if ({key_o, nonce_o, assoc_o, pt_o, tag_o, en_start_o, dec_start_o} !== 7'd0) begin
      n_errors++; $display("FAIL reset_serial: got %b required 0000000",
                           {key_o, nonce_o, assoc_o, pt_o, tag_o, en_start_o, dec_start_o});
    end
    n_checks++;
    if ({res_text, res_tag, res_auth, res_err} !== 170'd0) begin
      n_errors++; $display("FAIL reset_res: text=%h tag=%h auth=%b err=%b required all 0",
                           res_text, res_tag, res_auth, res_err);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, core_rst_o} !== 2'b10) begin
      n_errors++; $display("FAIL reset_release: ready,core_rst=%b required 10", {req_ready, core_rst_o});
    end
  endtask

  task automatic test_encrypt();
    logic [15:0] kw, pw;
    int early, stray;
    ascon(1'b0, K, NC, AD, PT, g_ct, g_tag);
    push_exp(1'b0, PT, 128'd0);
    start_req(1'b0, PT, 128'd0);
    n_checks++;
    if ({core_rst_o, req_ready} !== 2'b10) begin
      n_errors++; $display("FAIL enc_crst: core_rst,ready=%b required 10", {core_rst_o, req_ready});
    end
    kw = '0; pw = '0; early = 0; stray = 0;
    for (int n = 2; n <= 131; n++) begin
      @(negedge clk);
      if (n <= 17) begin kw = {kw[14:0], key_o}; pw = {pw[14:0], pt_o}; end
      if (n >= 42 && n <= 129 && (assoc_o || pt_o)) stray++;
      if (n >= 130 && (key_o || nonce_o || assoc_o || pt_o || tag_o)) stray++;
      if (n < 131 && (en_start_o || dec_start_o)) early++;
    end
    n_checks++;
    if ({en_start_o, dec_start_o} !== 2'b10 || early != 0) begin
      n_errors++; $display("FAIL enc_start_latency: en,dec=%b early=%0d required 10 early=0",
                           {en_start_o, dec_start_o}, early);
    end
    n_checks++;
    if (kw !== 16'h0001) begin
      n_errors++; $display("FAIL enc_key_serial: got %h required 0001", kw);
    end
    n_checks++;
    if (pw !== 16'h4142) begin
      n_errors++; $display("FAIL enc_pt_serial: got %h required 4142", pw);
    end
    n_checks++;
    if (stray != 0) begin
      n_errors++; $display("FAIL enc_serial_zero: %0d stray ones required 0", stray);
    end
    @(negedge clk);
    n_checks++;
    if (en_start_o !== 1'b0) begin
      n_errors++; $display("FAIL enc_start_width: en_start=%b required 0", en_start_o);
    end
    wait_result("enc");
  endtask

  task automatic test_decrypt();
    push_exp(1'b1, g_ct, g_tag);
    start_req(1'b1, g_ct, g_tag);
    wait_result("dec_good");
    push_exp(1'b1, g_ct, g_tag ^ 128'd1);
    start_req(1'b1, g_ct, g_tag ^ 128'd1);
    wait_result("dec_bad");
  endtask

  task automatic test_timeout();
    c_mute = 1;
    push_exp(1'b0, PT, 128'd0);
    start_req(1'b0, PT, 128'd0);
    for (int n = 2; n <= 148; n++) begin
      @(negedge clk);
      if (n == 147) begin
        n_checks++;
        if (res_valid !== 1'b0) begin
          n_errors++; $display("FAIL timeout_early: res_valid=%b required 0", res_valid);
        end
      end
    end
    n_checks++;
    if ({res_valid, res_err} !== 2'b11) begin
      n_errors++; $display("FAIL timeout_done: valid,err=%b required 11", {res_valid, res_err});
    end
    wait_result("timeout");
    c_mute = 0;
  endtask

  task automatic test_drop();
    c_drop = 50;
    push_exp(1'b0, PT, 128'd0);
    start_req(1'b0, PT, 128'd0);
    wait_result("drop50");
    c_drop = -1;
  endtask

  task automatic test_reset_mid();
    start_req(1'b0, PT, 128'd0);
    repeat (61) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_ready, core_rst_o, res_valid} !== 3'b110) begin
      n_errors++; $display("FAIL midrst_ctrl: ready,core_rst,valid=%b required 110", {req_ready, core_rst_o, res_valid});
    end
    n_checks++;
    if ({key_o, nonce_o, assoc_o, pt_o, tag_o} !== 5'd0) begin
      n_errors++; $display("FAIL midrst_serial: got %b required 00000", {key_o, nonce_o, assoc_o, pt_o, tag_o});
    end
    rst = 1'b0;
    push_exp(1'b0, PT, 128'd0);
    start_req(1'b0, PT, 128'd0);
    wait_result("after_reset");
  endtask

  task automatic test_back_to_back();
    int i, bad;
    push_exp(1'b0, PT, 128'd0);
    start_req(1'b0, PT, 128'd0);
    for (i = 0; i < 600 && !res_valid; i++) @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_errors++; $display("FAIL stall_wait: res_valid=%b required 1", res_valid);
    end
    push_exp(1'b1, g_ct, g_tag);
    drive_req(1'b1, g_ct, g_tag);
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_text !== sb[0].text || res_tag !== sb[0].tag) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++; $display("FAIL stall_hold: %0d unstable cycles required 0", bad);
    end
    wait_result("stall_enc");
    n_checks++;
    if ({req_ready, core_rst_o} !== 2'b10) begin
      n_errors++; $display("FAIL stall_idle: ready,core_rst=%b required 10", {req_ready, core_rst_o});
    end
    @(posedge clk);
    @(negedge clk);
    scramble_req();
    n_checks++;
    if ({req_ready, core_rst_o} !== 2'b01) begin
      n_errors++; $display("FAIL stall_accept: ready,core_rst=%b required 01", {req_ready, core_rst_o});
    end
    wait_result("stall_dec");
  endtask

  initial begin
    req_valid = 1'b0; req_mode = 1'b0; req_key = '0; req_nonce = '0;
    req_ad = '0; req_text = '0; req_tag = '0; res_ready = 1'b0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_timeout();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
